// File: rtl/spi_slave_regbank.sv
// SPI slave exposing a small register bank: a command word (R/W + start address) is followed
// by auto-incrementing data words. Everything runs on the SPI sampling clock.
module spi_slave_regbank #(
  parameter int unsigned       WORD_W    = 8,
  parameter int unsigned       ADDR_W    = 4,
  parameter int unsigned       NUM_REGS  = 12,
  parameter bit                MSB_FIRST = 1'b1,
  parameter logic [WORD_W-1:0] RESET_VAL = '0
) (
  input  logic                       w_SPI_Clk,
  input  logic                       i_Rst_L,
  input  logic                       i_SPI_CS_n,
  input  logic                       i_SPI_MOSI,
  output logic                       o_SPI_MISO,
  output logic                       o_SPI_MISO_OE,
  input  logic [WORD_W-1:0]          i_Status,
  output logic [NUM_REGS*WORD_W-1:0] o_Regs,
  output logic [ADDR_W-1:0]          o_Wr_Addr,
  output logic                       o_Wr_Toggle
);

  localparam int unsigned CNT_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;

  typedef enum logic [1:0] {StCmd, StTurn, StRd, StWr} state_e;

  state_e              r_state;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_preload;
  logic [WORD_W-1:0]   r_tx;
  logic [WORD_W-1:0]   r_rx;
  logic [ADDR_W-1:0]   r_addr;
  logic [WORD_W-1:0]   r_regs [NUM_REGS];
  logic [ADDR_W-1:0]   r_wr_addr;
  logic                r_wr_toggle;

  logic                w_word_end;
  logic                w_addr_ok;
  logic [WORD_W-1:0]   w_word;
  logic [WORD_W-1:0]   w_rd_data;
  logic [WORD_W-1:0]   w_status_shift;
  logic [WORD_W-1:0]   w_tx_shift;

  assign w_word_end = (r_cnt == CNT_W'(WORD_W - 1));
  assign w_addr_ok  = ({1'b0, r_addr} < (ADDR_W + 1)'(NUM_REGS));

  always_comb begin
    if (MSB_FIRST) begin
      w_word         = {r_rx[WORD_W-2:0], i_SPI_MOSI};
      w_status_shift = {i_Status[WORD_W-2:0], 1'b0};
      w_tx_shift     = {r_tx[WORD_W-2:0], 1'b0};
    end else begin
      w_word         = {i_SPI_MOSI, r_rx[WORD_W-1:1]};
      w_status_shift = {1'b0, i_Status[WORD_W-1:1]};
      w_tx_shift     = {1'b0, r_tx[WORD_W-1:1]};
    end
  end

  // Out-of-range addresses read as zero.
  always_comb begin
    w_rd_data = '0;
    for (int k = 0; k < NUM_REGS; k++) begin
      if (r_addr == ADDR_W'(k)) w_rd_data = r_regs[k];
    end
  end

  always_comb begin
    o_Regs = '0;
    for (int k = 0; k < NUM_REGS; k++) begin
      o_Regs[k*WORD_W +: WORD_W] = r_regs[k];
    end
  end

  // Frame state: cleared asynchronously whenever chip select is released.
  always_ff @(posedge w_SPI_Clk or negedge i_Rst_L or posedge i_SPI_CS_n) begin
    if (!i_Rst_L) begin
      r_state   <= StCmd;
      r_cnt     <= '0;
      r_preload <= 1'b1;
      r_tx      <= '0;
    end else if (i_SPI_CS_n) begin
      r_state   <= StCmd;
      r_cnt     <= '0;
      r_preload <= 1'b1;
      r_tx      <= '0;
    end else begin
      r_cnt     <= w_word_end ? '0 : r_cnt + 1'b1;
      r_preload <= 1'b0;
      if (r_preload) begin
        r_tx <= w_status_shift;
      end else if (w_word_end) begin
        r_tx <= ((r_state == StTurn) || (r_state == StRd)) ? w_rd_data : '0;
      end else begin
        r_tx <= w_tx_shift;
      end
      if (w_word_end) begin
        unique case (r_state)
          StCmd:   r_state <= w_word[WORD_W-1] ? StTurn : StWr;
          StTurn:  r_state <= StRd;
          default: r_state <= r_state;
        endcase
      end
    end
  end

  // Address, receive shifter and register bank survive chip-select release.
  always_ff @(posedge w_SPI_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      r_rx        <= '0;
      r_addr      <= '0;
      r_wr_addr   <= '0;
      r_wr_toggle <= 1'b0;
      for (int k = 0; k < NUM_REGS; k++) r_regs[k] <= RESET_VAL;
    end else if (!i_SPI_CS_n) begin
      r_rx <= w_word;
      if (w_word_end) begin
        unique case (r_state)
          StCmd: r_addr <= w_word[ADDR_W-1:0];
          StWr: begin
            r_addr <= r_addr + 1'b1;
            if (w_addr_ok) begin
              for (int k = 0; k < NUM_REGS; k++) begin
                if (r_addr == ADDR_W'(k)) r_regs[k] <= w_word;
              end
              r_wr_addr   <= r_addr;
              r_wr_toggle <= ~r_wr_toggle;
            end
          end
          default: r_addr <= r_addr + 1'b1;
        endcase
      end
    end
  end

  assign o_SPI_MISO    = r_preload ? (MSB_FIRST ? i_Status[WORD_W-1] : i_Status[0])
                                   : (MSB_FIRST ? r_tx[WORD_W-1] : r_tx[0]);
  assign o_SPI_MISO_OE = ~i_SPI_CS_n;
  assign o_Wr_Addr     = r_wr_addr;
  assign o_Wr_Toggle   = r_wr_toggle;

endmodule

// File: tb/tb_spi_slave_regbank.sv
// Bench for spi_slave_regbank: MSB-first and LSB-first instances driven with the same logical
// frames and checked against an array model of the register bank.
module tb_spi_slave_regbank;

  logic        clk;
  logic        rst_l;
  logic        cs_n;
  logic        mosi_m, mosi_l;
  logic        miso_m, miso_l;
  logic        oe_m, oe_l;
  logic [7:0]  status;
  logic [95:0] regs_m, regs_l;
  logic [3:0]  wa_m, wa_l;
  logic        tog_m, tog_l;

  spi_slave_regbank #(
    .WORD_W(8), .ADDR_W(4), .NUM_REGS(12), .MSB_FIRST(1'b1), .RESET_VAL(8'h00)
  ) u_dut_m (
    .w_SPI_Clk(clk), .i_Rst_L(rst_l), .i_SPI_CS_n(cs_n), .i_SPI_MOSI(mosi_m),
    .o_SPI_MISO(miso_m), .o_SPI_MISO_OE(oe_m), .i_Status(status), .o_Regs(regs_m),
    .o_Wr_Addr(wa_m), .o_Wr_Toggle(tog_m)
  );

  spi_slave_regbank #(
    .WORD_W(8), .ADDR_W(4), .NUM_REGS(12), .MSB_FIRST(1'b0), .RESET_VAL(8'h00)
  ) u_dut_l (
    .w_SPI_Clk(clk), .i_Rst_L(rst_l), .i_SPI_CS_n(cs_n), .i_SPI_MOSI(mosi_l),
    .o_SPI_MISO(miso_l), .o_SPI_MISO_OE(oe_l), .i_Status(status), .o_Regs(regs_l),
    .o_Wr_Addr(wa_l), .o_Wr_Toggle(tog_l)
  );

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0] fw    [9];
  logic [7:0] rxm   [9];
  logic [7:0] rxl   [9];
  logic [7:0] exp_rd[9];

  logic [7:0] m_regs [12];
  logic [3:0] m_wr_addr;
  logic       m_tog;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic model_reset();
    for (int k = 0; k < 12; k++) m_regs[k] = 8'h00;
    m_wr_addr = '0;
    m_tog     = 1'b0;
  endtask

  // Only complete words count; a read frame returns status, a zero turnaround, then registers.
  task automatic model_frame(input int n, output bit is_read);
    int base;
    int a;
    base    = int'(fw[0][3:0]);
    is_read = fw[0][7];
    for (int k = 0; k < n; k++) begin
      if (is_read) begin
        if (k == 0) exp_rd[k] = status;
        else if (k == 1) exp_rd[k] = 8'h00;
        else begin
          a = (base + k - 2) % 16;
          exp_rd[k] = (a < 12) ? m_regs[a] : 8'h00;
        end
      end else if (k > 0) begin
        a = (base + k - 1) % 16;
        if (a < 12) begin
          m_regs[a] = fw[k];
          m_wr_addr = 4'(a);
          m_tog     = ~m_tog;
        end
      end
    end
  endtask

  task automatic send_word(input logic [7:0] wd, input int nb, input int idx);
    for (int b = 0; b < nb; b++) begin
      mosi_m = wd[7-b];
      mosi_l = wd[b];
      #2;
      rxm[idx][7-b] = miso_m;
      rxl[idx][b]   = miso_l;
      #3 clk = 1'b1;
      #5 clk = 1'b0;
    end
  endtask

  task automatic run_frame(input int n, input int part_bits, input string tag);
    bit is_read;
    cs_n = 1'b0;
    #5;
    for (int w = 0; w < n; w++) send_word(fw[w], 8, w);
    if (part_bits > 0) send_word(8'h5C, part_bits, n);
    #2 cs_n = 1'b1;
    #5;
    model_frame(n, is_read);
    if (is_read) begin
      for (int k = 0; k < n; k++) begin
        check($sformatf("%s rd%0d msb", tag, k), 32'(rxm[k]), 32'(exp_rd[k]));
        check($sformatf("%s rd%0d lsb", tag, k), 32'(rxl[k]), 32'(exp_rd[k]));
      end
    end
  endtask

  task automatic check_state(input string tag);
    for (int k = 0; k < 12; k++) begin
      check($sformatf("%s reg%0d msb", tag, k), 32'(regs_m[k*8 +: 8]), 32'(m_regs[k]));
      check($sformatf("%s reg%0d lsb", tag, k), 32'(regs_l[k*8 +: 8]), 32'(m_regs[k]));
    end
    check({tag, " wr_addr msb"}, 32'(wa_m), 32'(m_wr_addr));
    check({tag, " wr_addr lsb"}, 32'(wa_l), 32'(m_wr_addr));
    check({tag, " toggle msb"}, 32'(tog_m), 32'(m_tog));
    check({tag, " toggle lsb"}, 32'(tog_l), 32'(m_tog));
  endtask

  initial begin
    clk    = 1'b0;
    cs_n   = 1'b1;
    mosi_m = 1'b0;
    mosi_l = 1'b0;
    status = 8'h00;
    rst_l  = 1'b0;
    model_reset();
    #10;
    check_state("reset");
    check("reset oe msb", 32'(oe_m), 32'd0);
    check("reset oe lsb", 32'(oe_l), 32'd0);
    rst_l = 1'b1;
    #10;

    // Plain write.
    fw[0] = 8'h03; fw[1] = 8'hA5; fw[2] = 8'h5A;
    run_frame(3, 0, "wr2");
    check_state("wr2");

    // Read with status; the first status bit must be on MISO before any clock edge.
    status = 8'hC3;
    cs_n   = 1'b0;
    #3;
    check("preload oe", 32'(oe_m), 32'd1);
    check("preload msb", 32'(miso_m), 32'd1);
    check("preload lsb", 32'(miso_l), 32'd1);
    cs_n = 1'b1;
    #5;
    fw[0] = 8'h83; fw[1] = 8'h00; fw[2] = 8'h00; fw[3] = 8'h00;
    run_frame(4, 0, "rd3");

    // Range limit and address wrap.
    fw[0] = 8'h0B; fw[1] = 8'h11; fw[2] = 8'h22;
    run_frame(3, 0, "wr_range");
    check_state("wr_range");
    fw[0] = 8'h8C; fw[1] = 8'hFF; fw[2] = 8'hFF;
    run_frame(3, 0, "rd_range");
    fw[0] = 8'h0F; fw[1] = 8'h33; fw[2] = 8'h44;
    run_frame(3, 0, "wr_wrap");
    check_state("wr_wrap");

    // Trailing partial word is dropped; next frame starts with a command.
    fw[0] = 8'h02; fw[1] = 8'hFF;
    run_frame(2, 5, "partial");
    check_state("partial");
    fw[0] = 8'h82; fw[1] = 8'h00; fw[2] = 8'h00; fw[3] = 8'h00;
    run_frame(4, 0, "after_partial");

    // Reset in the middle of a data word.
    cs_n = 1'b0;
    #5;
    send_word(8'h01, 8, 0);
    send_word(8'h77, 8, 1);
    send_word(8'h99, 3, 2);
    m_regs[1] = 8'h77; m_wr_addr = 4'd1; m_tog = ~m_tog;
    check_state("pre_rst");
    rst_l = 1'b0;
    #3;
    model_reset();
    check_state("mid_rst");
    rst_l = 1'b1;
    #2 cs_n = 1'b1;
    #5;

    // Randomized frames.
    for (int t = 0; t < 40; t++) begin
      int n;
      int part;
      n      = int'($urandom_range(1, 6));
      part   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 7)) : 0;
      status = 8'($urandom);
      fw[0]  = 8'($urandom);
      for (int k = 1; k < n; k++) fw[k] = 8'($urandom);
      run_frame(n, part, $sformatf("rnd%0d", t));
      check_state($sformatf("rnd%0d", t));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
